// File: rtl/axil_pwm_regslave.sv
// AXI4-Lite register slave driving a 4-channel up or up/down PWM counter.
// Optional macro AXI_PWM_SHADOW_EN: CMP0..3 are double-buffered and loaded at counter = 0.
module axil_pwm_regslave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [31:0] C_ID               = 32'hC0DE0004
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic [3:0]                        pwm_out
);
   localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned SW  = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned CW  = 16;
   localparam int unsigned NCH = 4;

   logic [1:0]            ctrl_q, ctrl_d;
   logic [CW-1:0]         period_q, period_d;
   logic [NCH-1:0][CW-1:0] cmp_q, cmp_d;
   logic [NCH-1:0][CW-1:0] cmp_act_c;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  dir_q, dir_d;
   logic [NCH-1:0]        pwm_q, pwm_d;
   logic                  awready_q, awready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [DW-1:0]         rd_word_c;
   logic [2:0]            wr_idx_c, rd_idx_c;
   logic                  wr_hs_c, rd_hs_c;
   logic                  unused_c;

   function automatic logic [CW-1:0] merge16(input logic [CW-1:0] cur,
                                             input logic [15:0]   data,
                                             input logic [1:0]    strb);
      merge16 = cur;
      if (strb[0]) merge16[7:0]  = data[7:0];
      if (strb[1]) merge16[15:8] = data[15:8];
   endfunction

   assign wr_idx_c = 3'(s00_axi_awaddr[AW-1:2]);
   assign rd_idx_c = 3'(s00_axi_araddr[AW-1:2]);
   assign wr_hs_c  = awready_q && s00_axi_awvalid && s00_axi_wvalid;
   assign rd_hs_c  = arready_q && s00_axi_arvalid;
   assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                       s00_axi_wdata[DW-1:16], s00_axi_wstrb[SW-1:2]};

`ifdef AXI_PWM_SHADOW_EN
   // Active compares follow the bus registers only at a period boundary or while stopped.
   logic [NCH-1:0][CW-1:0] cmp_act_q;
   logic                   load_c;
   assign load_c    = !ctrl_q[0] || (cnt_q == '0);
   assign cmp_act_c = load_c ? cmp_q : cmp_act_q;

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) cmp_act_q <= '0;
      else                  cmp_act_q <= cmp_act_c;
   end
`else
   assign cmp_act_c = cmp_q;
`endif

   always_comb begin
      ctrl_d    = ctrl_q;
      period_d  = period_q;
      cmp_d     = cmp_q;
      cnt_d     = '0;
      dir_d     = 1'b0;
      pwm_d     = '0;
      awready_d = 1'b0;
      bvalid_d  = bvalid_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rd_word_c = '0;

      // Write channel: one-cycle ready pulse, then register update and response.
      if (!awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q) awready_d = 1'b1;
      if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
      if (wr_hs_c) begin
         bvalid_d = 1'b1;
         case (wr_idx_c)
            3'd0: if (s00_axi_wstrb[0]) ctrl_d = s00_axi_wdata[1:0];
            3'd1: period_d = merge16(period_q, s00_axi_wdata[15:0], s00_axi_wstrb[1:0]);
            3'd2, 3'd3, 3'd4, 3'd5:
               cmp_d[2'(wr_idx_c - 3'd2)] = merge16(cmp_q[2'(wr_idx_c - 3'd2)],
                                                    s00_axi_wdata[15:0], s00_axi_wstrb[1:0]);
            default: ;
         endcase
      end

      // Read channel: data sampled at acceptance, so a colliding write is not yet visible.
      case (rd_idx_c)
         3'd0:                   rd_word_c = DW'(ctrl_q);
         3'd1:                   rd_word_c = DW'(period_q);
         3'd2, 3'd3, 3'd4, 3'd5: rd_word_c = DW'(cmp_q[2'(rd_idx_c - 3'd2)]);
         3'd6:                   rd_word_c = DW'(cnt_q);
         default:                rd_word_c = DW'(C_ID);
      endcase
      if (!arready_q && s00_axi_arvalid && !rvalid_q) arready_d = 1'b1;
      if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
      if (rd_hs_c) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word_c;
      end

      // Counter; a comparison against PERIOD (not equality) recovers when PERIOD shrinks.
      if (ctrl_q[0] && (period_q != '0)) begin
         if (!ctrl_q[1]) begin
            cnt_d = (cnt_q >= period_q) ? '0 : cnt_q + 16'd1;
         end else if (!dir_q) begin
            if (cnt_q >= period_q) begin
               cnt_d = cnt_q - 16'd1;
               dir_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end else if (cnt_q == '0) begin
            cnt_d = 16'd1;
         end else begin
            cnt_d = cnt_q - 16'd1;
            dir_d = 1'b1;
         end
      end

      for (int i = 0; i < NCH; i++) pwm_d[i] = ctrl_q[0] && (cnt_q < cmp_act_c[i]);
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         ctrl_q    <= '0;
         period_q  <= '0;
         cmp_q     <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         pwm_q     <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         period_q  <= period_d;
         cmp_q     <= cmp_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pwm_q     <= pwm_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = 2'b00;
   assign pwm_out         = pwm_q;
endmodule

// File: tb/tb_axil_pwm_regslave.sv
// Self-checking bench for axil_pwm_regslave: directed AXI steps plus randomized PWM setups
// checked against an arithmetic model of the counter and compare outputs.
module tb_axil_pwm_regslave;
   localparam logic [31:0] ID = 32'hC0DE0004;
`ifdef AXI_PWM_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif
   localparam int BIG = 1 << 30;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [4:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [3:0]  pwm_out;

   int checks = 0, failures = 0, cyc = 0;
   int m_period = 0, m_ud = 0, c_E = 0, c_W = BIG;
   int cmp_old[4], cmp_new[4], hi_cnt[4], mreg[8];

   axil_pwm_regslave dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
      .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
      .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
      .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
      .s00_axi_rready(rready), .pwm_out(pwm_out)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Counter value s cycles after enable, straight from the waveform definition.
   function automatic int f_cnt(input int s);
      int m;
      if (s < 0 || m_period == 0) return 0;
      if (m_ud == 0) return s % (m_period + 1);
      m = s % (2 * m_period);
      return (m <= m_period) ? m : 2 * m_period - m;
   endfunction

   // Whether the compare used for counter step s is the post-update one.
   function automatic bit use_new(input int s);
      int j0;
      if (!SHADOW) return (s + c_E >= c_W);
      j0 = (c_W - c_E > 0) ? c_W - c_E : 0;
      for (int j = j0; j <= s; j++) if (f_cnt(j) == 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_pwm(input int c);
      int s, cm;
      logic [3:0] r;
      r = '0;
      s = c - 1 - c_E;
      if (s >= 0)
         for (int i = 0; i < 4; i++) begin
            cm   = use_new(s) ? cmp_new[i] : cmp_old[i];
            r[i] = (f_cnt(s) < cm);
         end
      return r;
   endfunction

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output int hs);
      int n;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      chk("wr_awready", 32'(awready), 32'd1);
      chk("wr_wready", 32'(wready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      hs = cyc;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_awready_pulse", 32'(awready), 32'd0);
      chk("wr_bvalid", 32'(bvalid), 32'd1);
      chk("wr_bresp", 32'(bresp), 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("wr_bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output int acc);
      int n;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      chk("rd_arready", 32'(arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      arvalid = 1'b0;
      chk("rd_arready_pulse", 32'(arready), 32'd0);
      chk("rd_rvalid", 32'(rvalid), 32'd1);
      chk("rd_rresp", 32'(rresp), 32'd0);
      data = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      int acc;
      axi_read(addr, d, acc);
      chk(tag, d, exp);
   endtask

   task automatic configure(input int p, input int c0, input int c1, input int c2, input int c3);
      int hs;
      axi_write(5'h00, 32'd0, 4'hF, hs);
      axi_write(5'h04, 32'(p), 4'hF, hs);
      cmp_old[0] = c0; cmp_old[1] = c1; cmp_old[2] = c2; cmp_old[3] = c3;
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(8 + 4 * i), 32'(cmp_old[i]), 4'hF, hs);
         cmp_new[i] = cmp_old[i];
      end
      m_period = p; c_W = BIG;
   endtask

   task automatic enable(input logic [1:0] ctrl);
      int hs;
      axi_write(5'h00, 32'(ctrl), 4'hF, hs);
      c_E = hs; m_ud = int'(ctrl[1]);
   endtask

   task automatic check_pwm(input int n);
      logic [3:0] e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_pwm(cyc);
         chk("pwm_out", 32'(pwm_out), 32'(e));
         for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
      end
   endtask

   initial begin
      int hs, acc, n, cw, d, p, ud;
      logic [31:0] rd, v, old;
      logic [3:0] st;
      logic [4:0] a;

      // Reset state
      #12;
      chk("rst_awready", 32'(awready), 0); chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);   chk("rst_arready", 32'(arready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);   chk("rst_rdata", rdata, 0);
      chk("rst_pwm", 32'(pwm_out), 0);
      @(negedge clk); rst_n = 1'b1;

      // Basic write/read of CTRL, PERIOD, CMP0, CMP1
      axi_write(5'h00, 32'h1, 4'hF, hs); axi_write(5'h04, 32'h2, 4'hF, hs);
      axi_write(5'h08, 32'h3, 4'hF, hs); axi_write(5'h0C, 32'h4, 4'hF, hs);
      rd_chk("rb_ctrl", 5'h00, 32'h1); rd_chk("rb_period", 5'h04, 32'h2);
      rd_chk("rb_cmp0", 5'h08, 32'h3); rd_chk("rb_cmp1", 5'h0C, 32'h4);
      axi_write(5'h00, 32'h0, 4'hF, hs);

      // Byte strobes, ID, read-only registers, ignored low address bits
      axi_write(5'h08, 32'h0, 4'hF, hs);
      axi_write(5'h08, 32'hAABBCCDD, 4'b0001, hs);
      rd_chk("strb_lane0", 5'h08, 32'h000000DD);
      axi_write(5'h08, 32'hAABBCCDD, 4'b0010, hs);
      rd_chk("strb_lane1", 5'h0B, 32'h0000CCDD);
      rd_chk("id_read", 5'h1C, ID);
      axi_write(5'h1C, 32'h12345678, 4'hF, hs);
      rd_chk("id_after_write", 5'h1C, ID);
      axi_write(5'h18, 32'hFFFF, 4'hF, hs);
      rd_chk("status_ro", 5'h18, 32'h0);

      // awvalid without wvalid, then back-pressured response
      @(negedge clk);
      awaddr = 5'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("aw_only_awready", 32'(awready), 0); chk("aw_only_wready", 32'(wready), 0);
      end
      wvalid = 1'b1;
      @(negedge clk);
      chk("hs_awready", 32'(awready), 1); chk("hs_wready", 32'(wready), 1);
      @(posedge clk); @(negedge clk);
      chk("hs_awready_drop", 32'(awready), 0); chk("hs_wready_drop", 32'(wready), 0);
      chk("hs_bvalid", 32'(bvalid), 1);
      wdata = 32'h66;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_bvalid_held", 32'(bvalid), 1); chk("bp_write_stalled", 32'(awready), 0);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bp_bvalid_clear", 32'(bvalid), 0);
      n = 0;
      while (!awready && n < 5) begin @(negedge clk); n++; end
      chk("bp_second_awready", 32'(awready), 1);
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bp_second_bvalid", 32'(bvalid), 1);
      bready = 1'b1; @(negedge clk); bready = 1'b0;
      rd_chk("bp_period", 5'h04, 32'h66);

      // Up mode duty cycles
      configure(9, 3, 0, 12, 0);
      enable(2'b01);
      for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
      check_pwm(20);
      chk("duty_ch0", 32'(hi_cnt[0]), 32'd6);
      chk("duty_ch1", 32'(hi_cnt[1]), 32'd0);
      chk("duty_ch2", 32'(hi_cnt[2]), 32'd20);
      check_pwm(20);

      // Up/down mode, STATUS sampling, then reset with transactions in flight
      configure(4, 2, 5, 0, 3);
      enable(2'b11);
      check_pwm(12);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 7)) @(negedge clk);
         axi_read(5'h18, rd, acc);
         chk("ud_status", rd, 32'(f_cnt(acc - 1 - c_E)));
      end
      @(negedge clk);
      awaddr = 5'h14; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 5'h18; arvalid = 1'b1;
      n = 0;
      while (!(bvalid && rvalid) && n < 12) begin @(negedge clk); n++; end
      chk("inflight_bvalid", 32'(bvalid), 1); chk("inflight_rvalid", 32'(rvalid), 1);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pwm", 32'(pwm_out), 0); chk("arst_bvalid", 32'(bvalid), 0);
      chk("arst_rvalid", 32'(rvalid), 0); chk("arst_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      awaddr = 5'h04; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", 32'(awready), 1);
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("post_rst_bvalid", 32'(bvalid), 1);
      bready = 1'b1; @(negedge clk); bready = 1'b0;
      rd_chk("post_rst_ctrl", 5'h00, 0); rd_chk("post_rst_period", 5'h04, 7);
      rd_chk("post_rst_cmp3", 5'h14, 0); rd_chk("post_rst_status", 5'h18, 0);

      // PERIOD lowered below a running counter wraps at the next step
      configure(15, 4, 4, 4, 4);
      enable(2'b01);
      n = 0;
      while (f_cnt(cyc - c_E) != 5 && n < 40) begin @(negedge clk); n++; end
      axi_write(5'h04, 32'd3, 4'hF, hs);
      cw = f_cnt(hs - c_E);
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         axi_read(5'h18, rd, acc);
         d = acc - 1 - hs;
         chk("shrink_status", rd, 32'((cw >= 3) ? (d - 1) % 4 : (cw + d) % 4));
      end

      // CMP0 changed mid-period
      configure(9, 3, 0, 0, 0);
      enable(2'b01);
      n = 0;
      while (f_cnt(cyc - c_E) != 1 && n < 40) begin @(negedge clk); n++; end
      axi_write(5'h08, 32'd7, 4'hF, hs);
      c_W = hs; cmp_new[0] = 7;
      check_pwm(30);
      rd_chk("cmp0_readback", 5'h08, 32'd7);

      // Randomized register traffic with a register-file model
      axi_write(5'h00, 32'd0, 4'hF, hs);
      for (int i = 1; i < 6; i++) begin
         v = $urandom;
         axi_write(5'(4 * i), v, 4'hF, hs);
         mreg[i] = int'(v & 32'hFFFF);
      end
      for (int k = 0; k < 12; k++) begin
         n = $urandom_range(1, 5);
         v = $urandom; st = 4'($urandom);
         a = 5'(4 * n + $urandom_range(0, 3));
         axi_write(a, v, st, hs);
         old = 32'(mreg[n]);
         if (st[0]) old[7:0]  = v[7:0];
         if (st[1]) old[15:8] = v[15:8];
         mreg[n] = int'(old);
      end
      for (int i = 1; i < 6; i++) rd_chk("rand_reg", 5'(4 * i), 32'(mreg[i]));
      rd_chk("rand_id", 5'h1C, ID);

      // Randomized PWM configurations in both modes
      for (int k = 0; k < 6; k++) begin
         p = $urandom_range(1, 12);
         ud = $urandom_range(0, 1);
         configure(p, $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14),
                   $urandom_range(0, 14));
         enable({1'(ud), 1'b1});
         check_pwm(30 + $urandom_range(0, 10));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axil_pwm_regslave.md
AXIL_PWM_REGSLAVE -- requirements
Module: axil_pwm_regslave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 SHALL have parameter C_ID, default 32'hC0DE0004, constant returned by the ID register.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: s00_axi_aclk (input, 1, clock) and s00_axi_aresetn (input, 1, asynchronous active-low reset).
REQ-005 SHALL have AW channel: s00_axi_awaddr in 5 write addr; s00_axi_awprot in 3 ignored; s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-006 SHALL have W channel: s00_axi_wdata in 32; s00_axi_wstrb in 4 byte enables; s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-007 SHALL have B channel: s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-008 SHALL have AR channel: s00_axi_araddr in 5; s00_axi_arprot in 3 ignored; s00_axi_arvalid in 1; s00_axi_arready out 1.
REQ-009 SHALL have R channel: s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.
REQ-010 SHALL have pwm_out, output, 4, PWM channel outputs, registered.

Function
REQ-011 SHALL decode word index addr[4:2]: 0 CTRL (bit0 EN, bit1 UPDOWN), 1 PERIOD[15:0], 2..5 CMP0..CMP3[15:0], 6 STATUS (RO, counter value in [15:0]), 7 ID (RO, C_ID); addr[1:0] ignored.
REQ-012 SHALL accept a write only when awvalid and wvalid are both high and bvalid is low; awready and wready pulse high together for exactly one cycle.
REQ-013 SHALL update the register the cycle after acceptance, per byte lane with wstrb; unused bits read 0; writes to STATUS/ID are discarded.
REQ-014 SHALL assert bvalid the cycle after acceptance with bresp=2'b00 and hold it until bready is high; no new write is accepted while bvalid is high.
REQ-015 SHALL, on arvalid with rvalid low, pulse arready for one cycle, then assert rvalid next cycle with rdata captured at acceptance and rresp=2'b00, held stable until rready.
REQ-016 SHALL handle read and write channels independently; a read accepted in the same cycle as a write to the same register returns the pre-write value.
REQ-017 SHALL, when EN=0, hold counter at 0, direction up, and pwm_out at 4'b0000.
REQ-018 SHALL, in up mode (UPDOWN=0, EN=1), increment counter each cycle and wrap PERIOD -> 0.
REQ-019 SHALL, in up/down mode, count 0 up to PERIOD then down to 0, reversing at both ends (period 2*PERIOD cycles).
REQ-020 SHALL, with PERIOD=0, hold counter at 0.
REQ-021 SHALL drive pwm_out[i] one cycle after the counter as (EN && counter < CMPi); CMPi=0 gives constant low, CMPi>PERIOD gives constant high.
REQ-022 SHALL, if PERIOD is written below the current counter, wrap/reverse at the next step without passing 16'hFFFF.

Reset
REQ-023 SHALL, while s00_axi_aresetn is low, asynchronously clear all registers, counter, direction, pwm_out, awready, wready, bvalid, arready, rvalid, bresp, rresp and rdata to 0.
REQ-024 SHALL discard any transaction in flight at reset; after release, the first handshake is possible on the first rising edge.

Configuration
REQ-025 SHALL, with AXI_PWM_SHADOW_EN defined, write CMPi to a shadow register, load active compares when the counter is 0 (or continuously when EN=0); reads return the shadow value.
REQ-026 SHALL, without AXI_PWM_SHADOW_EN, apply CMPi writes directly to the active compare the cycle after the write.

Verification
REQ-027 SHALL cover writes 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C with wstrb=4'hF -> bresp OKAY each; reads return 0x1,0x2,0x3,0x4.
REQ-028 SHALL cover write 0xAABBCCDD to 0x08 with wstrb=4'b0001 after 0 -> reads 0x000000DD; read 0x1C -> C_ID; write to 0x1C -> ID unchanged.
REQ-029 SHALL cover awvalid held 5 cycles before wvalid -> no awready until wvalid; then awready=wready pulse once; bready low 3 cycles -> bvalid held, next write stalled.
REQ-030 SHALL cover PERIOD=9, CMP0=3, CMP1=0, CMP2=12, CTRL=1 -> pwm_out[0] high 3 of every 10 cycles, [1] low, [2] high.
REQ-031 SHALL cover CTRL=3, PERIOD=4 -> counter 0,1,2,3,4,3,2,1,0,...; aresetn low mid-count -> counter=0, pwm_out=0, bvalid=rvalid=0 immediately.
REQ-032 SHALL cover, with AXI_PWM_SHADOW_EN, CMP0 changed 3->7 mid-period -> pwm_out[0] duty changes only from the next counter=0; without it, it changes the next cycle.
